mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the CPU data bus (Dw*), downstream of the CPU data port.
//  CPU stores bytes into a TX FIFO; an 8N1 serializer drains it onto oTX at a programmable baud rate.
//  Status, control and divisor registers are readable over the same bus.
//  Provides a level IRQ for the interrupt controller.
// PARAMETERS
//  BASE_ADDR   32'hFF20_0100  word-aligned base of the 16-byte register window
//  FIFO_DEPTH  16             TX FIFO entries; power of 2, >= 2
//  CLK_HZ      50_000_000     iCLK frequency
//  BAUD        115200         reset baud; reset divisor DIV_RST = CLK_HZ/BAUD (434)
// PORTS
//  iCLK         in   1   system clock; all state updates on rising edge
//  iRST         in   1   synchronous, active-high reset
//  iReadEnable  in   1   bus read strobe (DwReadEnable)
//  iWriteEnable in   1   bus write strobe (DwWriteEnable)
//  iByteEnable  in   4   byte lanes of the write
//  iAddress     in   32  byte address
//  iWriteData   in   32  write data
//  oReadData    out  32  read data; 0 when not selected (OR-merged with other slaves)
//  oTX          out  1   serial line, idle high
//  oIRQ         out  1   level: CTRL.ie & FIFO empty & serializer idle
//  mFifoCount   out  $clog2(FIFO_DEPTH)+1  monitoring: FIFO occupancy
// BEHAVIOUR
//  Decode: sel = (iAddress[31:4] == BASE_ADDR[31:4]). Offset = iAddress[3:2].
//  Offset 0 DATA    W: push iWriteData[7:0] if iByteEnable[0]; R: 0.
//  Offset 1 STATUS  R: [0] full, [1] empty, [2] busy (state!=IDLE), [3] overflow (sticky), [15:8] count.
//  Offset 2 CTRL    R/W: [0] en (reset 1), [1] ie (reset 0). W1 self-clearing: [2] flush FIFO, [3] clear overflow.
//  Offset 3 BAUDDIV R/W: [15:0] divisor (reset DIV_RST). Writing 0 stores 1.
//  Reads: combinational, same cycle, no side effects. oReadData = 0 unless sel & iReadEnable.
//  Writes: take effect at the rising edge where sel & iWriteEnable.
//    CTRL/BAUDDIV lanes honour iByteEnable.
//  Reset values: oTX=1, oIRQ=0, FIFO empty, overflow=0, state IDLE, bit counter 0.
//  FIFO: push when full is dropped and sets overflow. Push and pop in the same edge leave count unchanged.
//    Flush in the same edge as a push: flush wins and the byte is lost.
//  FSM (registered oTX):
//    IDLE:  oTX=1. If en & !empty: pop into shift reg, baud cnt <= div-1, go START.
//    START: oTX=0 for div cycles, then DATA with bit index 0.
//    DATA:  oTX=shift[0] (LSB first), div cycles per bit; after bit 7 go STOP.
//    STOP:  oTX=1 for div cycles, then IDLE.
//  Frame = 10*div cycles. Back-to-back frames have exactly 1 idle-high cycle between them.
//  First start bit appears on oTX 1 cycle after the popping edge.
//  Divisor change: the counter reload uses the new value from the next bit boundary on.
//    The current bit completes with the old value.
//  Clearing en or flushing mid-frame: the current frame completes; no further pops.
//  iRST mid-frame: line returns high next cycle and the frame is abandoned.
// STRUCTURE
//  Shared include (Parametros.v): register offsets, STATUS/CTRL bit indices, FSM state encodings.
//  Sub-module: sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH).
//    Ports: push, pop, flush, din, dout, full, empty, count.
//    First-word-fall-through dout.
//  Top level holds the decode/register file, baud counter, shifter and FSM.
// TESTING
//  Reset, then read STATUS -> 0x00000002 (empty). oTX=1, oIRQ=0, BAUDDIV reads 434.
//  BAUDDIV=4, write DATA=0x55 -> oTX: 0 then 1,0,1,0,1,0,1,0 then 1, each held 4 cycles, 40 cycles total.
//  Write 17 bytes with en=0 -> count=16, full=1, overflow=1. CTRL bit3 write -> overflow=0.
//  Queue 0xA5,0x3C at div=2 -> two frames, 20 cycles each, exactly 1 idle cycle between them.
//  Set ie=1 after draining -> oIRQ=1. Push a byte -> oIRQ=0 on the next cycle.
//  Flush plus 2-byte writes mid-frame -> current frame completes, no further frames, empty=1.
//  Write DATA with iByteEnable=4'b1110 -> no push.
//  Read at BASE_ADDR+0x20 -> oReadData=0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, register bit positions, serializer state encoding and a helper
// that assembles the STATUS word.
package mmio_uart_tx_pkg;

    // Word offsets inside the 16-byte register window (iAddress[3:2])
    localparam logic [1:0] OFS_DATA    = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_CTRL    = 2'd2;
    localparam logic [1:0] OFS_BAUDDIV = 2'd3;

    // STATUS bit positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 8;

    // CTRL bit positions; FLUSH and CLROVF are write-one strobes, never stored
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int CTRL_FLUSH_BIT  = 2;
    localparam int CTRL_CLROVF_BIT = 3;

    // Serializer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Build the STATUS read word from its individual flags
    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                              = '0;
        word[STAT_FULL_BIT]               = full;
        word[STAT_EMPTY_BIT]              = empty;
        word[STAT_BUSY_BIT]               = busy;
        word[STAT_OVF_BIT]                = ovf;
        word[STAT_CNT_LSB +: 8]           = count;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pushes into a full FIFO and pops
// from an empty one are ignored; flush empties the FIFO and beats a
// simultaneous push or pop.
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head entry is always presented so the consumer can take it on the pop edge
    assign dout = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush has priority over traffic
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. The CPU stores bytes into a TX FIFO
// through the DATA register; a serializer drains it onto oTX at the rate set
// by BAUDDIV. STATUS, CTRL and BAUDDIV are readable on the same bus.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFF20_0100,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iReadEnable,
    input  logic                          iWriteEnable,
    input  logic [3:0]                    iByteEnable,
    input  logic [31:0]                   iAddress,
    input  logic [31:0]                   iWriteData,
    output logic [31:0]                   oReadData,
    output logic                          oTX,
    output logic                          oIRQ,
    output logic [$clog2(FIFO_DEPTH):0]   mFifoCount
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

    // Bus decode
    logic        sel;
    logic [1:0]  offset;
    logic        wr_sel;
    logic        wr_data;
    logic        wr_ctrl;
    logic        wr_div;

    // Control / status registers
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    logic [15:0] div_merged;

    // Serializer
    tx_state_e   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] baud_cnt_q;
    logic        tx_q;
    logic        busy;

    // FIFO interface
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Address bits and write lanes that no register uses
    logic unused_bits;
    assign unused_bits = ^{iAddress[1:0], iWriteData[31:16], iByteEnable[3:2]};

    assign sel     = (iAddress[31:4] == BASE_ADDR[31:4]);
    assign offset  = iAddress[3:2];
    assign wr_sel  = sel & iWriteEnable;
    assign wr_data = wr_sel & (offset == OFS_DATA) & iByteEnable[0];
    assign wr_ctrl = wr_sel & (offset == OFS_CTRL) & iByteEnable[0];
    assign wr_div  = wr_sel & (offset == OFS_BAUDDIV) & (|iByteEnable[1:0]);

    assign fifo_push  = wr_data;
    assign fifo_flush = wr_ctrl & iWriteData[CTRL_FLUSH_BIT];
    assign fifo_pop   = (state_q == TX_IDLE) & en_q & ~fifo_empty;

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .srst  (iRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (iWriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Divisor lanes: each enabled byte lane replaces its byte of the old value
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div_lane
            assign div_merged[gi*8 +: 8] = iByteEnable[gi] ? iWriteData[gi*8 +: 8]
                                                           : div_q[gi*8 +: 8];
        end
    endgenerate

    // Next-state of the control registers from bus writes and FIFO overflow
    always_comb begin
        en_d  = en_q;
        ie_d  = ie_q;
        ovf_d = ovf_q;
        div_d = div_q;
        if (wr_ctrl) begin
            en_d = iWriteData[CTRL_EN_BIT];
            ie_d = iWriteData[CTRL_IE_BIT];
            if (iWriteData[CTRL_CLROVF_BIT]) begin
                ovf_d = 1'b0;
            end
        end
        // A dropped byte outranks a clear in the same cycle; a flushed byte is not an overflow
        if (fifo_push && fifo_full && !fifo_flush) begin
            ovf_d = 1'b1;
        end
        if (wr_div) begin
            // A zero divisor would stall the baud counter, so it is stored as 1
            div_d = (div_merged == 16'd0) ? 16'd1 : div_merged;
        end
    end

    // Control register state
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            en_q  <= 1'b1;
            ie_q  <= 1'b0;
            ovf_q <= 1'b0;
            div_q <= DIV_RST;
        end else begin
            en_q  <= en_d;
            ie_q  <= ie_d;
            ovf_q <= ovf_d;
            div_q <= div_d;
        end
    end

    // Serializer FSM; oTX is registered from the state so the line follows one cycle later
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= TX_IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= 1'b1;
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_dout;
                        baud_cnt_q <= div_q - 16'd1;
                        bit_idx_q  <= 3'd0;
                        state_q    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_cnt_q == 16'd0) begin
                        baud_cnt_q <= div_q - 16'd1;
                        bit_idx_q  <= 3'd0;
                        state_q    <= TX_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_cnt_q == 16'd0) begin
                        baud_cnt_q <= div_q - 16'd1;
                        shift_q    <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_cnt_q == 16'd0) begin
                        bit_idx_q <= 3'd0;
                        state_q   <= TX_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
            endcase

            case (state_q)
                TX_START: tx_q <= 1'b0;
                TX_DATA:  tx_q <= shift_q[0];
                default:  tx_q <= 1'b1;
            endcase
        end
    end

    assign busy       = (state_q != TX_IDLE);
    assign oTX        = tx_q;
    assign oIRQ       = ie_q & fifo_empty & ~busy;
    assign mFifoCount = fifo_count;

    // Combinational read mux; drives zero when this slave is not addressed
    always_comb begin
        oReadData = 32'h0;
        if (sel && iReadEnable) begin
            case (offset)
                OFS_STATUS:  oReadData = pack_status(fifo_full, fifo_empty, busy, ovf_q,
                                                     8'(fifo_count));
                OFS_CTRL:    oReadData = {30'h0, ie_q, en_q};
                OFS_BAUDDIV: oReadData = {16'h0, div_q};
                default:     oReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus tasks drive register accesses, bytes expected
// on the line are queued in a scoreboard and a line monitor decodes every
// frame cycle by cycle and compares it against the queue head.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFF20_0100;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_DIV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        iRST;
    logic        iReadEnable;
    logic        iWriteEnable;
    logic [3:0]  iByteEnable;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oTX;
    logic        oIRQ;
    logic [4:0]  mFifoCount;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (16),
        .CLK_HZ     (50_000_000),
        .BAUD       (115200)
    ) dut (
        .iCLK         (clk),
        .iRST         (iRST),
        .iReadEnable  (iReadEnable),
        .iWriteEnable (iWriteEnable),
        .iByteEnable  (iByteEnable),
        .iAddress     (iAddress),
        .iWriteData   (iWriteData),
        .oReadData    (oReadData),
        .oTX          (oTX),
        .oIRQ         (oIRQ),
        .mFifoCount   (mFifoCount)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_wr_cyc = 0;
    int tb_div = 4;
    int frames_done = 0;
    bit in_frame = 1'b0;
    logic [7:0] exp_q [$];
    int start_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        iAddress     = addr;
        iWriteData   = data;
        iByteEnable  = be;
        iWriteEnable = 1'b1;
        @(posedge clk);
        #1;
        iWriteEnable = 1'b0;
        iByteEnable  = 4'h0;
        last_wr_cyc  = cyc;
        $display("wr   addr=%08h data=%08h be=%b", addr, data, be);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        iAddress    = addr;
        iReadEnable = 1'b1;
        #1;
        d = oReadData;
        iReadEnable = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_wr(A_DATA, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_reached", frames_done, n);
    endtask

    // Line monitor: decodes each frame and scores it against the queue head
    initial begin : line_monitor
        logic       prev_tx;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic [9:0] fb;
        int         nbad;
        int         d;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_tx === 1'b1 && oTX === 1'b0) begin
                in_frame = 1'b1;
                d = tb_div;
                start_q.push_back(cyc);
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                fb    = {1'b1, exp_b, 1'b0};
                nbad  = 0;
                got_b = 8'h00;
                for (int c = 0; c < 10 * d; c++) begin
                    if (c > 0) @(negedge clk);
                    if (oTX !== fb[c / d]) nbad++;
                    if (c / d >= 1 && c / d <= 8 && c % d == d / 2) got_b[c / d - 1] = oTX;
                end
                chk("frame_data", {24'h0, got_b}, {24'h0, exp_b});
                chk("frame_shape_errs", nbad, 0);
                frames_done++;
                in_frame = 1'b0;
            end
            prev_tx = oTX;
        end
    end

    initial begin : stimulus
        int k;
        iRST = 1'b1;
        iReadEnable = 1'b0;
        iWriteEnable = 1'b0;
        iByteEnable = 4'h0;
        iAddress = 32'h0;
        iWriteData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        iRST = 1'b0;

        // Reset state
        chk("rst_tx", {31'h0, oTX}, 32'd1);
        chk("rst_irq", {31'h0, oIRQ}, 32'd0);
        chk("rst_count", {27'h0, mFifoCount}, 32'd0);
        rd_chk("rst_status", A_STAT, 32'h0000_0002);
        rd_chk("rst_ctrl", A_CTRL, 32'h0000_0001);
        rd_chk("rst_bauddiv", A_DIV, 32'd434);

        // Single frame at divisor 4, with start-bit latency
        bus_wr(A_DIV, 32'd4, 4'hF);
        rd_chk("bauddiv_4", A_DIV, 32'd4);
        tb_div = 4;
        send_byte(8'h55);
        k = last_wr_cyc;
        wait_frames(1, 200);
        chk("start_latency", start_q[0] - k, 2);

        // Overflow with serializer disabled, then clear and flush
        bus_wr(A_CTRL, 32'h0, 4'h1);
        for (int i = 0; i < 17; i++) bus_wr(A_DATA, 32'h10 + i, 4'h1);
        @(negedge clk);
        chk("full_count", {27'h0, mFifoCount}, 32'd16);
        rd_chk("status_full_ovf", A_STAT, 32'h0000_1009);
        bus_wr(A_CTRL, 32'h8, 4'h1);
        rd_chk("status_ovf_clr", A_STAT, 32'h0000_1001);
        bus_wr(A_CTRL, 32'h4, 4'h1);
        rd_chk("status_flushed", A_STAT, 32'h0000_0002);
        bus_wr(A_DATA, 32'h77, 4'b1110);
        @(negedge clk);
        chk("no_push_be", {27'h0, mFifoCount}, 32'd0);

        // Back-to-back frames at divisor 2
        bus_wr(A_DIV, 32'd2, 4'hF);
        tb_div = 2;
        bus_wr(A_CTRL, 32'h1, 4'h1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        wait_frames(3, 200);
        chk("b2b_start_gap", start_q[2] - start_q[1], 21);
        rd_chk("status_drained", A_STAT, 32'h0000_0002);

        // Interrupt
        bus_wr(A_CTRL, 32'h3, 4'h1);
        chk("irq_set", {31'h0, oIRQ}, 32'd1);
        send_byte(8'h81);
        chk("irq_clr_on_push", {31'h0, oIRQ}, 32'd0);
        wait_frames(4, 200);
        @(negedge clk);
        chk("irq_after_drain", {31'h0, oIRQ}, 32'd1);
        bus_wr(A_CTRL, 32'h1, 4'h1);

        // Flush plus pushes mid-frame: only the frame in flight completes
        send_byte(8'hC3);
        k = 0;
        while (!in_frame && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_frame", {31'h0, in_frame}, 32'd1);
        bus_wr(A_DATA, 32'h11, 4'h1);
        bus_wr(A_DATA, 32'h22, 4'h1);
        bus_wr(A_CTRL, 32'h5, 4'h1);
        wait_frames(5, 200);
        repeat (40) @(negedge clk);
        chk("no_extra_frames", frames_done, 5);
        rd_chk("status_after_flush", A_STAT, 32'h0000_0002);

        // Decode, zero divisor and byte lanes
        rd_chk("read_outside", BASE + 32'h20, 32'h0);
        rd_chk("read_data_reg", A_DATA, 32'h0);
        @(negedge clk);
        iAddress = A_STAT;
        #1;
        chk("no_read_enable", oReadData, 32'h0);
        bus_wr(A_DIV, 32'h0, 4'hF);
        rd_chk("bauddiv_zero", A_DIV, 32'd1);
        bus_wr(A_DIV, 32'h0000_1234, 4'b0010);
        rd_chk("bauddiv_lane1", A_DIV, 32'h0000_1201);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a hung run still reports
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
